// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file random sequencer:
// FSM state encoding, LFSR feedback taps, default seed and LFSR helpers.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    READ = 3'd2,
    HOLD = 3'd3,
    WB   = 3'd4
  } state_t;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One Fibonacci step: shift left, XOR of the tapped bits enters bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [15:0] legal_seed(input logic [15:0] s);
    return (s == 16'h0000) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/regfile_rand_seq_lfsr16.sv
// 16-bit Fibonacci LFSR with enable. The seed is loaded only by reset;
// a zero seed is substituted with the default so the register never locks.
module lfsr16
  import regfile_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift register: reseeded by reset only, advances one step when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= legal_seed(seed);
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/regfile_rand_seq.sv
// Sequencer for a 2^N x W dual-read register file (reg0 reads as zero).
// A start in IDLE fills registers 1..2^N-1 with LFSR data, then every
// TICK_DIV cycles a random register pair is read, captured and offered
// downstream. Optional writeback is enabled by defining
// REGFILE_SEQ_WRITEBACK_EN: each accepted sample then writes rs1+rs2 back
// to addr1 in one extra WB cycle.
//
// Output handshake: out_valid rises with a capture and the out_* fields
// stay frozen until a cycle where out_valid && out_ready, which is the one
// and only transfer; stop drops out_valid and discards the sample.
module regfile_rand_seq
  import regfile_seq_pkg::*;
#(
  parameter int          N        = 4,
  parameter int          W        = 8,
  parameter int          TICK_DIV = 4,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         done_fill,
  output logic         rf_we,
  output logic [N-1:0] rf_addr_rd,
  output logic [W-1:0] rf_data_in,
  output logic [N-1:0] rf_addr_rs1,
  output logic [N-1:0] rf_addr_rs2,
  input  logic [W-1:0] rf_rs1,
  input  logic [W-1:0] rf_rs2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_addr1,
  output logic [N-1:0] out_addr2,
  output logic [W-1:0] out_rs1,
  output logic [W-1:0] out_rs2,
  output state_t       dbg_state,
  output logic [15:0]  dbg_lfsr
);

  localparam int             TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [N-1:0]   FILL_FIRST = N'(1);
  localparam logic [N-1:0]   FILL_LAST  = {N{1'b1}};

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tick_q;
  logic [N-1:0]  fill_addr_q;
  logic [15:0]   lfsr_q;
  logic          lfsr_en;
  logic          tick_last;
  logic          sample_fire;
  logic          out_fire;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  // Read addresses come straight from the LFSR register.
  assign rf_addr_rs1 = lfsr_q[N-1:0];
  assign rf_addr_rs2 = lfsr_q[2*N-1:N];

  assign tick_last   = (tick_q == TICK_LAST);
  // A sample is taken on the last tick unless stop aborts it.
  assign sample_fire = (state_q == READ) && tick_last && !stop;
  // out_valid is high throughout HOLD, so ready alone completes the transfer.
  assign out_fire    = (state_q == HOLD) && out_ready && !stop;

  assign busy      = (state_q != IDLE);
  assign done_fill = (state_q == READ) || (state_q == HOLD) || (state_q == WB);
  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = FILL;
        FILL: if (fill_addr_q == FILL_LAST) state_d = READ;
        READ: if (tick_last) state_d = HOLD;
`ifdef REGFILE_SEQ_WRITEBACK_EN
        HOLD: if (out_ready) state_d = WB;
        WB:   state_d = READ;
`else
        HOLD: if (out_ready) state_d = READ;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Register-file write port and LFSR advance, decoded from the current state.
  always_comb begin
    rf_we      = 1'b0;
    rf_addr_rd = '0;
    rf_data_in = '0;
    lfsr_en    = 1'b0;
    case (state_q)
      FILL: begin
        rf_we      = 1'b1;
        rf_addr_rd = fill_addr_q;
        rf_data_in = lfsr_q[W-1:0];
        lfsr_en    = 1'b1;
      end
      READ: begin
        lfsr_en = sample_fire;
      end
`ifdef REGFILE_SEQ_WRITEBACK_EN
      WB: begin
        // Writing reg0 would be meaningless, so the write is suppressed there.
        rf_we      = (out_addr1 != '0);
        rf_addr_rd = out_addr1;
        rf_data_in = out_rs1 + out_rs2;
        lfsr_en    = (out_addr1 != '0);
      end
`endif
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  // Tick counter: runs only while staying in READ, otherwise parked at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else if ((state_q == READ) && (state_d == READ)) begin
      tick_q <= tick_q + TW'(1);
    end else begin
      tick_q <= '0;
    end
  end

  // Fill address: held at 1 while idle so every fill starts at reg1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_addr_q <= FILL_FIRST;
    end else if (state_q == IDLE) begin
      fill_addr_q <= FILL_FIRST;
    end else if (state_q == FILL) begin
      fill_addr_q <= fill_addr_q + N'(1);
    end
  end

  // Capture registers and out_valid for the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr1 <= '0;
      out_addr2 <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
    end else if (sample_fire) begin
      out_valid <= 1'b1;
      out_addr1 <= rf_addr_rs1;
      out_addr2 <= rf_addr_rs2;
      out_rs1   <= rf_rs1;
      out_rs2   <= rf_rs2;
    end else if (stop || out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_rand_seq.sv
// Directed testbench for regfile_rand_seq (N=4, W=8, TICK_DIV=4, SEED=ACE1).
// The bench models the register file (reg0 reads zero) and the LFSR, and
// checks fill writes, sampled pairs, hold behaviour, stop and reset.
module tb_regfile_rand_seq;
  import regfile_seq_pkg::*;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int TICK_DIV = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy, done_fill, rf_we, out_valid;
  logic [N-1:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2, out_addr1, out_addr2;
  logic [W-1:0] rf_data_in, rf_rs1, rf_rs2, out_rs1, out_rs2;
  state_t       dbg_state;
  logic [15:0]  dbg_lfsr;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_lfsr;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_byte;

  // Register-file model; non-zero initial contents make untouched regs visible.
  logic [W-1:0] rf_mem [16] = '{8'h00, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97,
                                8'h98, 8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F};

  regfile_rand_seq #(.N(N), .W(W), .TICK_DIV(TICK_DIV), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy), .done_fill(done_fill),
    .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_data_in(rf_data_in),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr1(out_addr1), .out_addr2(out_addr2),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
  );

  // Clock
  always #5 clk = ~clk;

  // Register-file write port model
  always @(posedge clk) begin
    if (rf_we && rf_addr_rd != 0) rf_mem[rf_addr_rd] <= rf_data_in;
  end

  assign rf_rs1 = (rf_addr_rs1 == 0) ? '0 : rf_mem[rf_addr_rs1];
  assign rf_rs2 = (rf_addr_rs2 == 0) ? '0 : rf_mem[rf_addr_rs2];

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic logic [W-1:0] model_rd(input logic [N-1:0] a);
    return (a == 0) ? '0 : rf_mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample cycle starting at READ tick 0: four idle ticks, capture, optional
  // hold with out_ready low, then the handshake (and WB cycle when enabled).
  task automatic do_sample(input int hold_cycles);
    logic [N-1:0] a1, a2;
    logic [W-1:0] d1, d2;
    a1 = exp_lfsr[N-1:0];
    a2 = exp_lfsr[2*N-1:N];
    for (int t = 0; t < TICK_DIV; t++) begin
      check("read_valid_low", 32'(out_valid), 32'd0);
      tick();
    end
    d1 = model_rd(a1);
    d2 = model_rd(a2);
    exp_lfsr = lfsr_step(exp_lfsr);
    check("cap_valid", 32'(out_valid), 32'd1);
    check("cap_addr1", 32'(out_addr1), 32'(a1));
    check("cap_addr2", 32'(out_addr2), 32'(a2));
    check("cap_rs1", 32'(out_rs1), 32'(d1));
    check("cap_rs2", 32'(out_rs2), 32'(d2));
    check("cap_lfsr", 32'(dbg_lfsr), 32'(exp_lfsr));
    if (hold_cycles > 0) begin
      out_ready = 1'b0;
      for (int h = 0; h < hold_cycles; h++) begin
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_addr1", 32'(out_addr1), 32'(a1));
        check("hold_rs2", 32'(out_rs2), 32'(d2));
        check("hold_lfsr", 32'(dbg_lfsr), 32'(exp_lfsr));
        check("hold_state", 32'(dbg_state), 32'(HOLD));
      end
      out_ready = 1'b1;
    end
    tick();
    check("hs_valid_low", 32'(out_valid), 32'd0);
`ifdef REGFILE_SEQ_WRITEBACK_EN
    check("wb_state", 32'(dbg_state), 32'(WB));
    check("wb_we", 32'(rf_we), (a1 != 0) ? 32'd1 : 32'd0);
    if (a1 != 0) begin
      check("wb_addr", 32'(rf_addr_rd), 32'(a1));
      check("wb_data", 32'(rf_data_in), 32'(W'(d1 + d2)));
      exp_lfsr = lfsr_step(exp_lfsr);
    end
    tick();
`endif
    check("hs_state_read", 32'(dbg_state), 32'(READ));
  endtask

  initial begin
    // ---- 1: reset, partial fill, reset asserted mid-FILL ----
    rst_n = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_lfsr", 32'(dbg_lfsr), 32'hACE1);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f1_we", 32'(rf_we), 32'd1);
    check("f1_addr", 32'(rf_addr_rd), 32'd1);
    check("f1_data", 32'(rf_data_in), 32'hE1);
    tick();
    check("f2_data", 32'(rf_data_in), 32'hC3);
    tick();
    check("f3_data", 32'(rf_data_in), 32'h87);
    tick();
    check("f4_addr", 32'(rf_addr_rd), 32'd4);
    check("f4_data", 32'(rf_data_in), 32'h0F);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(rf_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr_rd", 32'(rf_addr_rd), 32'd0);
    check("midrst_data_in", 32'(rf_data_in), 32'd0);
    check("midrst_done", 32'(done_fill), 32'd0);
    #2 rst_n = 1'b1;
    check("rel_lfsr", 32'(dbg_lfsr), 32'hACE1);
    check("rel_rs1_addr", 32'(rf_addr_rs1), 32'h1);
    check("rel_rs2_addr", 32'(rf_addr_rs2), 32'hE);
    check("rel_reg4_untouched", 32'(rf_mem[4]), 32'h94);
    tick();

    // ---- 5: stop during fill at addr 7, then restart ----
    exp_lfsr = 16'hACE1;
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back(exp_lfsr[W-1:0]);
      exp_lfsr = lfsr_step(exp_lfsr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      exp_byte = exp_q.pop_front();
      check("s_fill_we", 32'(rf_we), 32'd1);
      check("s_fill_addr", 32'(rf_addr_rd), 32'(i));
      check("s_fill_data", 32'(rf_data_in), 32'(exp_byte));
      if (i == 7) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    check("stop_we", 32'(rf_we), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_state", 32'(dbg_state), 32'(IDLE));
    check("stop_lfsr", 32'(dbg_lfsr), 32'h70F2);
    tick();
    check("stop_reg7", 32'(rf_mem[7]), 32'h79);
    for (int i = 8; i <= 15; i++) begin
      check("stop_untouched", 32'(rf_mem[i]), 32'(8'h90 + i));
    end

    // ---- 2: full fill continuing the LFSR sequence ----
    for (int i = 1; i <= 15; i++) begin
      exp_q.push_back(exp_lfsr[W-1:0]);
      exp_lfsr = lfsr_step(exp_lfsr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("refill_first", 32'(rf_data_in), 32'hF2);
    for (int i = 1; i <= 15; i++) begin
      exp_byte = exp_q.pop_front();
      check("fill_we", 32'(rf_we), 32'd1);
      check("fill_addr", 32'(rf_addr_rd), 32'(i));
      check("fill_data", 32'(rf_data_in), 32'(exp_byte));
      check("fill_done_low", 32'(done_fill), 32'd0);
      tick();
    end
    check("fill_end_we", 32'(rf_we), 32'd0);
    check("fill_end_done", 32'(done_fill), 32'd1);
    check("fill_end_state", 32'(dbg_state), 32'(READ));
    check("fill_end_lfsr", 32'(dbg_lfsr), 32'(exp_lfsr));
    check("fill_reg0_model", 32'(rf_mem[0]), 32'd0);

    // ---- 3: free-running samples, start held high (ignored outside IDLE) ----
    out_ready = 1'b1;
    start = 1'b1;
    for (int s = 0; s < 10; s++) begin
      do_sample(0);
    end
    check("start_ignored_busy", 32'(busy), 32'd1);

    // ---- 4: hold 10 cycles with out_ready low, then one transfer ----
    do_sample(10);
    do_sample(0);

    // ---- stop while a sample is pending, start in the same cycle ----
    for (int t = 0; t < TICK_DIV; t++) tick();
    exp_lfsr = lfsr_step(exp_lfsr);
    check("pend_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_done", 32'(done_fill), 32'd0);
    check("abort_we", 32'(rf_we), 32'd0);
    tick();
    check("abort_stays_idle", 32'(dbg_state), 32'(IDLE));
    check("abort_lfsr", 32'(dbg_lfsr), 32'(exp_lfsr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
